// File: rtl/glitcbus_slave_if.sv
// GLITCBUS pins plus the local register-bus handshake, bundled for the slave.
// Slave drives GAD out/oe and the register strobe; master side is the TISC/bench.
interface glitcbus_slave_if;
    logic        gsel_b_i;
    logic        grdwr_b_i;
    logic [7:0]  gad_i;
    logic [7:0]  gad_o;
    logic        gad_oe_o;
    logic [7:0]  reg_adr_o;
    logic [31:0] reg_dat_o;
    logic        reg_we_o;
    logic        reg_stb_o;
    logic [31:0] reg_dat_i;
    logic        reg_ack_i;
    logic        busy_o;
    logic        collision_o;
    logic        timeout_o;

    modport slave (
        input  gsel_b_i, grdwr_b_i, gad_i, reg_dat_i, reg_ack_i,
        output gad_o, gad_oe_o, reg_adr_o, reg_dat_o, reg_we_o, reg_stb_o,
        output busy_o, collision_o, timeout_o
    );

    modport master (
        output gsel_b_i, grdwr_b_i, gad_i, reg_dat_i, reg_ack_i,
        input  gad_o, gad_oe_o, reg_adr_o, reg_dat_o, reg_we_o, reg_stb_o,
        input  busy_o, collision_o, timeout_o
    );
endinterface

// File: rtl/glitcbus_slave.sv
// GLITCBUS responder: 1 address byte + 4 write bytes -> register strobe, or strobe -> 4 read bytes.
// Read data appears TURNAROUND cycles after the address; no backpressure, late selects raise collision.
module glitcbus_slave #(
    parameter int          TURNAROUND    = 2,
    parameter int          WRITE_TIMEOUT = 8,
    parameter logic [31:0] DEAD_VALUE    = 32'hDEADDEAD
) (
    input  logic             clk_i,
    input  logic             rst_b_i,
    glitcbus_slave_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        WSTROBE,
        RWAIT,
        RDATA,
        RRELEASE
    } state_t;

    state_t      state;
    logic [1:0]  bcnt;
    logic [15:0] tcnt;
    logic [15:0] rcnt;
    logic [31:0] rd_buf;
    logic        rd_got;
    logic [31:0] rd_sel;

    // Word handed to the GAD serialiser at the read deadline.
    always_comb begin
        rd_sel = DEAD_VALUE;
        if (rd_got)
            rd_sel = rd_buf;
        else if (bus.reg_ack_i)
            rd_sel = bus.reg_dat_i;
    end

    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            state           <= IDLE;
            bcnt            <= 2'd0;
            tcnt            <= 16'd0;
            rcnt            <= 16'd0;
            rd_buf          <= 32'd0;
            rd_got          <= 1'b0;
            bus.gad_o       <= 8'd0;
            bus.gad_oe_o    <= 1'b0;
            bus.reg_adr_o   <= 8'd0;
            bus.reg_dat_o   <= 32'd0;
            bus.reg_we_o    <= 1'b0;
            bus.reg_stb_o   <= 1'b0;
            bus.busy_o      <= 1'b0;
            bus.collision_o <= 1'b0;
            bus.timeout_o   <= 1'b0;
        end else begin
            bus.collision_o <= 1'b0;
            bus.timeout_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.gsel_b_i) begin
                        bus.reg_adr_o <= bus.gad_i;
                        bus.busy_o    <= 1'b1;
                        if (bus.grdwr_b_i) begin
                            state         <= RWAIT;
                            bus.reg_stb_o <= 1'b1;
                            bus.reg_we_o  <= 1'b0;
                            rcnt          <= 16'd1;
                            rd_got        <= 1'b0;
                        end else begin
                            state <= WDATA;
                            bcnt  <= 2'd0;
                        end
                    end
                end
                WDATA: begin
                    if (bus.gsel_b_i) begin
                        state      <= IDLE;
                        bus.busy_o <= 1'b0;
                    end else begin
                        bus.reg_dat_o[{bcnt, 3'b000} +: 8] <= bus.gad_i;
                        bcnt <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            state         <= WSTROBE;
                            bus.reg_stb_o <= 1'b1;
                            bus.reg_we_o  <= 1'b1;
                            tcnt          <= 16'd0;
                        end
                    end
                end
                WSTROBE: begin
                    // Select here is a protocol violation, not an abort.
                    if (!bus.gsel_b_i)
                        bus.collision_o <= 1'b1;
                    if (bus.reg_ack_i) begin
                        bus.reg_stb_o <= 1'b0;
                        state         <= IDLE;
                        bus.busy_o    <= 1'b0;
                    end else if (tcnt == 16'(WRITE_TIMEOUT - 1)) begin
                        bus.reg_stb_o <= 1'b0;
                        bus.timeout_o <= 1'b1;
                        state         <= IDLE;
                        bus.busy_o    <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                RWAIT: begin
                    if (bus.gsel_b_i) begin
                        bus.reg_stb_o <= 1'b0;
                        state         <= IDLE;
                        bus.busy_o    <= 1'b0;
                    end else begin
                        if (!rd_got && bus.reg_ack_i) begin
                            rd_buf        <= bus.reg_dat_i;
                            rd_got        <= 1'b1;
                            bus.reg_stb_o <= 1'b0;
                        end
                        if (rcnt == 16'(TURNAROUND)) begin
                            state         <= RDATA;
                            bus.reg_stb_o <= 1'b0;
                            bus.gad_oe_o  <= 1'b1;
                            bus.gad_o     <= rd_sel[7:0];
                            rd_buf        <= rd_sel;
                            bcnt          <= 2'd1;
                        end else begin
                            rcnt <= rcnt + 16'd1;
                        end
                    end
                end
                RDATA: begin
                    if (bus.gsel_b_i) begin
                        bus.gad_oe_o <= 1'b0;
                        bus.gad_o    <= 8'd0;
                        state        <= IDLE;
                        bus.busy_o   <= 1'b0;
                    end else if (bcnt == 2'd0) begin
                        // bcnt wrapped: all four bytes have been on GAD.
                        bus.gad_oe_o <= 1'b0;
                        bus.gad_o    <= 8'd0;
                        state        <= RRELEASE;
                    end else begin
                        bus.gad_o <= rd_buf[{bcnt, 3'b000} +: 8];
                        bcnt      <= bcnt + 2'd1;
                    end
                end
                RRELEASE: begin
                    if (!bus.gsel_b_i)
                        bus.collision_o <= 1'b1;
                    state      <= IDLE;
                    bus.busy_o <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    bus.busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glitcbus_slave.sv
// Scoreboard bench for glitcbus_slave: expected strobes and GAD bytes are queued when driven.
module tb_glitcbus_slave;
    localparam int          T    = 2;
    localparam int          WT   = 8;
    localparam logic [31:0] DEAD = 32'hDEADDEAD;

    typedef struct {
        logic [7:0]  adr;
        logic [31:0] dat;
        logic        we;
        int          len;
    } stb_exp_t;

    logic clk;
    logic rst_b;
    glitcbus_slave_if bus();

    glitcbus_slave #(
        .TURNAROUND   (T),
        .WRITE_TIMEOUT(WT),
        .DEAD_VALUE   (DEAD)
    ) dut (
        .clk_i  (clk),
        .rst_b_i(rst_b),
        .bus    (bus)
    );

    int         n_chk = 0;
    int         n_err = 0;
    int         n_coll = 0;
    int         n_to = 0;
    int         stb_len = 0;
    logic       skip_gad = 1'b0;
    stb_exp_t   stb_q[$];
    logic [7:0] gad_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: sample just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!rst_b) begin
            stb_len = 0;
        end else begin
            if (bus.reg_stb_o) begin
                stb_len++;
            end else if (stb_len != 0) begin
                if (stb_q.size() == 0) begin
                    chk("stb_unexpected", 32'd1, 32'd0);
                end else begin
                    stb_exp_t e;
                    e = stb_q.pop_front();
                    chk("stb_adr", {24'd0, bus.reg_adr_o}, {24'd0, e.adr});
                    chk("stb_we", {31'd0, bus.reg_we_o}, {31'd0, e.we});
                    if (e.we)
                        chk("stb_dat", bus.reg_dat_o, e.dat);
                    chk("stb_len", stb_len, e.len);
                end
                stb_len = 0;
            end
            if (bus.gad_oe_o && !skip_gad) begin
                if (gad_q.size() == 0)
                    chk("gad_unexpected", 32'd1, 32'd0);
                else
                    chk("gad_byte", {24'd0, bus.gad_o}, {24'd0, gad_q.pop_front()});
            end
            if (bus.collision_o) n_coll++;
            if (bus.timeout_o) n_to++;
        end
    end

    // ack_d: strobe cycles until ack (0 = never); abort_k/coll_k: edge offset from A (0 = none).
    task automatic do_write(input logic [7:0] adr, input logic [31:0] dat,
                            input int ack_d, input int abort_k, input int coll_k);
        int c0;
        int t0;
        stb_exp_t e;
        c0 = n_coll;
        t0 = n_to;
        if (abort_k == 0) begin
            e.adr = adr; e.dat = dat; e.we = 1'b1; e.len = (ack_d != 0) ? ack_d : WT;
            stb_q.push_back(e);
        end
        @(negedge clk);
        bus.gsel_b_i = 1'b0; bus.grdwr_b_i = 1'b0; bus.gad_i = adr;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                bus.gsel_b_i = (abort_k != 0 && k >= abort_k);
                bus.gad_i    = dat[8*(k-1) +: 8];
            end else begin
                bus.gsel_b_i = (k != coll_k);
                bus.gad_i    = 8'h00;
            end
            bus.reg_ack_i = (ack_d != 0 && k == 4 + ack_d);
        end
        bus.reg_ack_i = 1'b0;
        chk("wr_timeout", n_to - t0, (abort_k == 0 && ack_d == 0) ? 1 : 0);
        chk("wr_collision", n_coll - c0, (coll_k != 0) ? 1 : 0);
        chk("wr_busy_end", {31'd0, bus.busy_o}, 32'd0);
    endtask

    // ack_k: edge offset from A where ack is sampled (0 = never).
    task automatic do_read(input logic [7:0] adr, input logic [31:0] rdat, input int ack_k);
        logic [31:0] w;
        int c0;
        stb_exp_t e;
        c0 = n_coll;
        w = (ack_k >= 1 && ack_k <= T) ? rdat : DEAD;
        e.adr = adr; e.dat = 32'd0; e.we = 1'b0; e.len = (ack_k >= 1 && ack_k <= T) ? ack_k : T;
        stb_q.push_back(e);
        for (int i = 0; i < 4; i++) gad_q.push_back(w[8*i +: 8]);
        @(negedge clk);
        bus.gsel_b_i = 1'b0; bus.grdwr_b_i = 1'b1; bus.gad_i = adr; bus.reg_dat_i = rdat;
        for (int k = 1; k <= T + 4; k++) begin
            @(negedge clk);
            if (k == T)     chk("rd_oe_pre", {31'd0, bus.gad_oe_o}, 32'd0);
            if (k == T + 1) chk("rd_oe_first", {31'd0, bus.gad_oe_o}, 32'd1);
            bus.reg_ack_i = (k == ack_k);
            bus.gad_i     = 8'hA5;
        end
        @(negedge clk);
        bus.reg_ack_i = 1'b0; bus.gsel_b_i = 1'b1;
        chk("rd_release_oe", {31'd0, bus.gad_oe_o}, 32'd0);
        chk("rd_busy_release", {31'd0, bus.busy_o}, 32'd1);
        @(negedge clk);
        chk("rd_busy_end", {31'd0, bus.busy_o}, 32'd0);
        chk("rd_collision", n_coll - c0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        stb_exp_t e;
        rst_b = 1'b0;
        bus.gsel_b_i = 1'b1; bus.grdwr_b_i = 1'b1; bus.gad_i = 8'h00;
        bus.reg_dat_i = 32'd0; bus.reg_ack_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_oe", {31'd0, bus.gad_oe_o}, 32'd0);
        chk("rst_stb", {31'd0, bus.reg_stb_o}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_adr", {24'd0, bus.reg_adr_o}, 32'd0);
        chk("rst_dat", bus.reg_dat_o, 32'd0);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);

        do_write(8'h12, 32'hDEADBEEF, 2, 0, 0);
        do_read(8'h34, 32'h12345678, 1);
        do_read(8'h56, 32'hCAFEBABE, T + 1);
        do_write(8'h21, 32'hCAFEF00D, 0, 3, 0);
        do_write(8'h33, 32'h01020304, 0, 0, 0);
        do_write(8'h44, 32'hA5A55A5A, 3, 0, 6);
        do_read(8'h9A, 32'h0BADF00D, 2);

        // Reset in the middle of the read-data phase.
        e.adr = 8'h66; e.dat = 32'd0; e.we = 1'b0; e.len = 1;
        stb_q.push_back(e);
        skip_gad = 1'b1;
        @(negedge clk);
        bus.gsel_b_i = 1'b0; bus.grdwr_b_i = 1'b1; bus.gad_i = 8'h66; bus.reg_dat_i = 32'h87654321;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.reg_ack_i = (k == 1);
        end
        @(posedge clk);
        #1;
        chk("mid_oe_before_rst", {31'd0, bus.gad_oe_o}, 32'd1);
        #1;
        rst_b = 1'b0;
        #1;
        chk("mid_rst_oe", {31'd0, bus.gad_oe_o}, 32'd0);
        chk("mid_rst_gad", {24'd0, bus.gad_o}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("mid_rst_adr", {24'd0, bus.reg_adr_o}, 32'd0);
        chk("mid_rst_dat", bus.reg_dat_o, 32'd0);
        chk("mid_rst_we", {31'd0, bus.reg_we_o}, 32'd0);
        @(negedge clk);
        bus.gsel_b_i = 1'b1; bus.reg_ack_i = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        skip_gad = 1'b0;
        gad_q.delete();
        @(negedge clk);

        do_write(8'h77, 32'h11223344, 1, 0, 0);
        repeat (3) @(negedge clk);
        chk("end_stb_q", stb_q.size(), 0);
        chk("end_gad_q", gad_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
